// File: rtl/mem_tbus_arb_pkg.sv
// Shared definitions for the load-pipe / store-queue dcache bus arbiter:
// the arbiter FSM state encoding, the tbus operation-type codes and the
// bus data width.
package mem_tbus_arb_pkg;

    // Arbiter FSM: one dcache transaction outstanding at a time.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_LD = 2'd1,
        ST_BUSY_SQ = 2'd2
    } arb_state_e;

    // tbus operation-type codes.
    localparam logic [1:0] TBUS_OP_READ  = 2'b00;
    localparam logic [1:0] TBUS_OP_WRITE = 2'b01;

    // Width of the index, data and mask buses.
    localparam int TBUS_DATA_W = 64;

endpackage : mem_tbus_arb_pkg

// File: rtl/mem_tbus_arb.sv
// Arbiter between the load pipe and the store queue for a single dcache tbus
// port. In IDLE the winning request passes through combinationally, so there
// is zero added latency. The selected requester sees ready only when tbus
// is ready. Load pipe has fixed priority. When ARB_STARVE_GUARD_EN is defined,
// a counter lets the store queue win after SQ_STARVE_LIMIT consecutive load
// grants taken while the store queue was waiting.
// Ports: clock/reset_n (async active-low); ld2arb_* load-pipe request and
// response plus ld2arb_kill; sq2arb_* store-queue request and response;
// tbus_* dcache request (valid/ready + payload) and response (done + data).
module mem_tbus_arb
    import mem_tbus_arb_pkg::*;
#(
    parameter int SQ_STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    // load pipe
    input  logic        ld2arb_tbus_index_valid,
    output logic        ld2arb_tbus_index_ready,
    input  logic [63:0] ld2arb_tbus_index,
    input  logic [63:0] ld2arb_tbus_write_data,
    input  logic [63:0] ld2arb_tbus_write_mask,
    input  logic [1:0]  ld2arb_tbus_operation_type,
    output logic [63:0] ld2arb_tbus_read_data,
    output logic        ld2arb_tbus_operation_done,
    input  logic        ld2arb_kill,
    // store queue
    input  logic        sq2arb_tbus_index_valid,
    output logic        sq2arb_tbus_index_ready,
    input  logic [63:0] sq2arb_tbus_index,
    input  logic [63:0] sq2arb_tbus_write_data,
    input  logic [63:0] sq2arb_tbus_write_mask,
    input  logic [1:0]  sq2arb_tbus_operation_type,
    output logic [63:0] sq2arb_tbus_read_data,
    output logic        sq2arb_tbus_operation_done,
    // dcache
    output logic        tbus_index_valid,
    input  logic        tbus_index_ready,
    output logic [63:0] tbus_index,
    output logic [63:0] tbus_write_data,
    output logic [63:0] tbus_write_mask,
    output logic [1:0]  tbus_operation_type,
    input  logic [63:0] tbus_read_data,
    input  logic        tbus_operation_done
);

    arb_state_e state_q, state_d;
    // A kill seen earlier in the current load transaction; the done is dropped.
    logic       kill_q, kill_d;

    logic       any_vld;
    logic       sel_sq;
    logic       grant;
    logic       starve_override;

    assign any_vld = ld2arb_tbus_index_valid | sq2arb_tbus_index_valid;
    // Store queue wins only when the load pipe is idle or it has been starved.
    assign sel_sq  = sq2arb_tbus_index_valid &
                     (~ld2arb_tbus_index_valid | starve_override);
    assign grant   = (state_q == ST_IDLE) & any_vld & tbus_index_ready;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(SQ_STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_override = (starve_cnt_q >= CNT_W'(SQ_STARVE_LIMIT));

    // Counts load grants taken while the store queue is waiting. It cannot
    // exceed the limit: at the limit the next grant goes to the store queue.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!sq2arb_tbus_index_valid || (grant && sel_sq)) begin
            starve_cnt_d = '0;
        end else if (grant) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^SQ_STARVE_LIMIT;
    assign starve_override     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d                    = state_q;
        kill_d                     = kill_q;
        tbus_index_valid           = 1'b0;
        tbus_index                 = '0;
        tbus_write_data            = '0;
        tbus_write_mask            = '0;
        tbus_operation_type        = TBUS_OP_READ;
        ld2arb_tbus_index_ready    = 1'b0;
        sq2arb_tbus_index_ready    = 1'b0;
        ld2arb_tbus_operation_done = 1'b0;
        sq2arb_tbus_operation_done = 1'b0;
        ld2arb_tbus_read_data      = '0;
        sq2arb_tbus_read_data      = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A stray done while idle (e.g. after a reset) is dropped.
                tbus_index_valid = any_vld;
                if (any_vld) begin
                    if (sel_sq) begin
                        tbus_index          = sq2arb_tbus_index;
                        tbus_write_data     = sq2arb_tbus_write_data;
                        tbus_write_mask     = sq2arb_tbus_write_mask;
                        tbus_operation_type = sq2arb_tbus_operation_type;
                    end else begin
                        tbus_index          = ld2arb_tbus_index;
                        tbus_write_data     = ld2arb_tbus_write_data;
                        tbus_write_mask     = ld2arb_tbus_write_mask;
                        tbus_operation_type = ld2arb_tbus_operation_type;
                    end
                end
                kill_d = 1'b0;
                if (grant) begin
                    ld2arb_tbus_index_ready = ~sel_sq;
                    sq2arb_tbus_index_ready = sel_sq;
                    state_d = sel_sq ? ST_BUSY_SQ : ST_BUSY_LD;
                end
            end
            ST_BUSY_LD: begin
                if (ld2arb_kill) begin
                    kill_d = 1'b1;
                end
                if (tbus_operation_done) begin
                    // A kill in the done cycle itself also suppresses the done.
                    if (!kill_q && !ld2arb_kill) begin
                        ld2arb_tbus_operation_done = 1'b1;
                        ld2arb_tbus_read_data      = tbus_read_data;
                    end
                    kill_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_SQ: begin
                if (tbus_operation_done) begin
                    sq2arb_tbus_operation_done = 1'b1;
                    sq2arb_tbus_read_data      = tbus_read_data;
                    state_d                    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : mem_tbus_arb

// File: doc/mem_tbus_arb.md
MEM_TBUS_ARB -- requirements
Module: mem_tbus_arb

Interface
REQ-001 SHALL have parameter SQ_STARVE_LIMIT, default 8, max consecutive load-pipe grants while store queue waits.
REQ-002 SHALL have ports: clock  input  1  system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 ld2arb_tbus_index_valid / ld2arb_tbus_index_ready  input / output  1  load-pipe request handshake.
REQ-005 ld2arb_tbus_index, ld2arb_tbus_write_data, ld2arb_tbus_write_mask  input  64 each  load-pipe request payload.
REQ-006 ld2arb_tbus_operation_type  input  2  load-pipe op type.
REQ-007 ld2arb_tbus_read_data / ld2arb_tbus_operation_done  output  64 / 1  load-pipe response.
REQ-008 ld2arb_kill  input  1  squash of the load in flight (redirect).
REQ-009 sq2arb_tbus_index_valid / sq2arb_tbus_index_ready  input / output  1  store-queue handshake.
REQ-010 sq2arb_tbus_index, sq2arb_tbus_write_data, sq2arb_tbus_write_mask  input  64 each  store payload.
REQ-011 sq2arb_tbus_operation_type  input  2  store-queue op type.
REQ-012 sq2arb_tbus_read_data / sq2arb_tbus_operation_done  output  64 / 1  store response.
REQ-013 tbus_index_valid / tbus_index_ready  output / input  1  dcache request handshake.
REQ-014 tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type  output  64/64/64/2  dcache payload.
REQ-015 tbus_read_data / tbus_operation_done  input  64 / 1  dcache response.

Function
REQ-016 FSM states SHALL be IDLE, BUSY_LD, BUSY_SQ; one transaction outstanding at a time.
REQ-017 In IDLE, tbus_index_valid SHALL equal ld valid OR sq valid; payload SHALL be the selected requester's, combinational (zero added latency).
REQ-018 Selection SHALL be load-pipe first unless the starvation override (REQ-027) is active.
REQ-019 Grant SHALL occur when IDLE, tbus_index_valid and tbus_index_ready are all high: the selected requester's ready is 1 that cycle, the other's is 0; FSM moves to BUSY_LD or BUSY_SQ next cycle.
REQ-020 Both requester readies SHALL be 0 in BUSY_* and whenever tbus_index_ready is 0.
REQ-021 tbus_index_valid SHALL be 0 in BUSY_*.
REQ-022 In BUSY_x, tbus_operation_done SHALL be forwarded to x's operation_done the same cycle with tbus_read_data; FSM returns to IDLE the next cycle.
REQ-023 Non-owner operation_done SHALL stay 0; read_data outputs SHALL show tbus_read_data only while their done is high, else 0.
REQ-024 ld2arb_kill in BUSY_LD (any cycle up to and including the done cycle) SHALL suppress ld2arb_tbus_operation_done for that transaction; FSM still waits for tbus_operation_done.
REQ-025 ld2arb_kill SHALL be ignored in IDLE and BUSY_SQ.
REQ-026 tbus_operation_done in IDLE SHALL be ignored (no output, no state change).

Configuration
REQ-027 With ARB_STARVE_GUARD_EN defined: a counter SHALL increment on each load grant while sq valid is high, clear on each store grant or when sq valid is low; at SQ_STARVE_LIMIT the store queue SHALL win the next arbitration.
REQ-028 Without ARB_STARVE_GUARD_EN: no counter; pure fixed load priority.

Reset
REQ-029 On reset_n low SHALL asynchronously force IDLE, counter 0; with no valids every output is 0.
REQ-030 Reset mid-transaction SHALL abandon it; a late tbus_operation_done after reset SHALL be ignored per REQ-026.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, 2-bit tbus op-type constants (read/write) and 64-bit bus width constant.
REQ-032 No sub-module; the starvation counter is inline.

Verification
REQ-033 Only sq valid, index 0x80, tbus ready 1 -> sq ready 1 same cycle, tbus_index 0x80; done 3 cycles later -> sq done 1, ld done 0.
REQ-034 ld and sq valid together, tbus ready 1 -> ld granted; sq granted first IDLE cycle after ld done.
REQ-035 tbus ready 0 for 4 cycles with ld valid -> ld ready 0 throughout, payload stable, grant on cycle 5.
REQ-036 Load granted, ld2arb_kill pulse in BUSY_LD, done with read_data 0xDEAD -> ld done stays 0, FSM to IDLE.
REQ-037 Guard on, LIMIT 8, ld and sq continuously valid -> 9th grant goes to sq, counter clears; guard off -> sq never granted.
REQ-038 reset_n low during BUSY_SQ, then done pulse -> no done output, state IDLE.
